voxel_fetch: RTL and testbench

VOXEL_FETCH -- requirements
Module: voxel_fetch

---
 rtl/voxel_fetch_if.sv | 27 ++
 rtl/voxel_fetch.sv | 130 +++++++++++++
 tb/tb_voxel_fetch.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voxel_fetch_if.sv
// Voxel fetch bus bundle: Avalon-MM read master plus the show-ahead voxel stream.
// The master modport is the fetch engine's view; slave is the memory/ray-stage side.
interface voxel_fetch_if;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        m_readdatavalid;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (
        output m_address, m_read,
        input  m_waitrequest, m_readdata, m_readdatavalid,
        output out_data, out_valid, out_last,
        input  out_ready
    );

    modport slave (
        input  m_address, m_read,
        output m_waitrequest, m_readdata, m_readdatavalid,
        input  out_data, out_valid, out_last,
        output out_ready
    );
endinterface

// File: rtl/voxel_fetch.sv
// Voxel fetch engine: streams count words from base_addr over pipelined Avalon-MM reads
// into a show-ahead output FIFO, issuing reads only when FIFO space is reserved for them.
//
// state | meaning
// IDLE  | waiting for start; late read data is discarded
// FETCH | issuing reads while credit allows
// DRAIN | all reads issued; waiting for data to arrive and leave the FIFO
module voxel_fetch #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [31:0] count,
    output logic        busy,
    output logic        done,
    voxel_fetch_if.master bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t        state;
    logic [31:0]   count_q;
    logic [31:0]   issued;
    logic [31:0]   received;
    logic [31:0]   popped;
    logic [31:0]   addr_q;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   mem [FIFO_DEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count_n;
    logic [31:0]   received_n;

    assign fifo_empty = (fifo_count == '0);

    // Credit: every in-flight read already owns a FIFO slot, so pushes never overflow.
    assign bus.m_read    = (state == FETCH) && (issued < count_q) &&
                           (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_W);
    assign bus.m_address = addr_q;

    assign accept       = bus.m_read && !bus.m_waitrequest;
    assign push         = bus.m_readdatavalid && (state != IDLE);
    assign pop          = !fifo_empty && bus.out_ready;
    assign fifo_count_n = fifo_count + CW'(push) - CW'(pop);
    assign received_n   = received + 32'(push);

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_empty ? '0 : mem[rd_ptr];
    assign bus.out_last  = !fifo_empty && (popped == count_q - 32'd1);
    assign busy          = (state != IDLE);

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= bus.m_readdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            done        <= 1'b0;
            count_q     <= '0;
            issued      <= '0;
            received    <= '0;
            popped      <= '0;
            addr_q      <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            done        <= 1'b0;
            fifo_count  <= fifo_count_n;
            received    <= received_n;
            outstanding <= outstanding + CW'(accept) - CW'(push);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                popped <= popped + 32'd1;
            end
            if (accept) begin
                issued <= issued + 32'd1;
                addr_q <= addr_q + 32'd4;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        count_q     <= count;
                        addr_q      <= base_addr;
                        issued      <= '0;
                        received    <= '0;
                        popped      <= '0;
                        outstanding <= '0;
                        if (count == 32'd0) begin
                            done <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (accept && (issued + 32'd1 == count_q)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((received_n == count_q) && (fifo_count_n == '0)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_voxel_fetch.sv
// Bench for voxel_fetch: Avalon slave model with configurable stall/latency, a scoreboard
// deriving every expected address and word from base + 4*k, and directed plus random fetches.
module tb_voxel_fetch;
    localparam int DEPTH = 8;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] count;
    logic        busy;
    logic        done;

    voxel_fetch_if vif();

    voxel_fetch #(.FIFO_DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .bus       (vif)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } beat_t;

    typedef struct {
        logic [31:0] base;
        int          cnt;
        int          lat;
        int          rdy;
        int          wmode;
        logic [31:0] first_a;
        logic [31:0] last_a;
        int          words;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          ready_mode = 1;
    int          wait_mode = 0;
    int          acc_k = 0;
    int          pop_k = 0;
    int          done_cnt = 0;
    int          stall_cnt = 0;
    int          exp_count = 0;
    logic [31:0] exp_base = '0;
    logic [31:0] first_addr = '0;
    logic [31:0] last_addr = '0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    bit          prev_stall = 0;
    bit          prev_hold = 0;
    beat_t       rq[$];
    vec_t        vecs[5];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave side drivers: read data returns in order, lat cycles after acceptance.
    initial begin
        vif.m_waitrequest   = 1'b0;
        vif.m_readdata      = '0;
        vif.m_readdatavalid = 1'b0;
        vif.out_ready       = 1'b1;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            vif.m_readdatavalid = 1'b0;
            vif.m_readdata      = $urandom;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                vif.m_readdatavalid = 1'b1;
                vif.m_readdata      = rq[0].data;
                void'(rq.pop_front());
            end
            case (wait_mode)
                1:       vif.m_waitrequest = ($urandom_range(0, 2) == 0);
                2:       vif.m_waitrequest = (acc_k == 1 && stall_cnt < 3);
                default: vif.m_waitrequest = 1'b0;
            endcase
            case (ready_mode)
                0:       vif.out_ready = 1'b0;
                2:       vif.out_ready = 1'($urandom_range(0, 1));
                default: vif.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor and scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_stall = 0;
                prev_hold  = 0;
            end else begin
                if (prev_stall) begin
                    check("read_hold", 32'(vif.m_read), 32'd1);
                    check("addr_hold", vif.m_address, prev_addr);
                end
                prev_stall = vif.m_read && vif.m_waitrequest;
                prev_addr  = vif.m_address;
                if (wait_mode == 2 && vif.m_read && vif.m_waitrequest && acc_k == 1)
                    stall_cnt++;
                if (prev_hold) begin
                    check("valid_hold", 32'(vif.out_valid), 32'd1);
                    check("data_hold", vif.out_data, prev_data);
                end
                prev_hold = vif.out_valid && !vif.out_ready;
                prev_data = vif.out_data;

                if (vif.m_read && !vif.m_waitrequest) begin
                    if (acc_k >= exp_count) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_read: addr %h after %0d reads, expected %0d", vif.m_address, acc_k, exp_count);
                    end else begin
                        check("rd_addr", vif.m_address, exp_base + 32'(4 * acc_k));
                        if (acc_k == 0) first_addr = vif.m_address;
                        last_addr = vif.m_address;
                        rq.push_back('{data: word_at(vif.m_address), due: cyc + lat});
                        acc_k++;
                        check("credit", 32'(acc_k - pop_k <= DEPTH), 32'd1);
                    end
                end

                if (vif.out_valid && vif.out_ready) begin
                    if (pop_k >= exp_count) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_word: data %h after %0d words, expected %0d", vif.out_data, pop_k, exp_count);
                    end else begin
                        check("out_data", vif.out_data, word_at(exp_base + 32'(4 * pop_k)));
                        check("out_last", 32'(vif.out_last), 32'(pop_k == exp_count - 1));
                        pop_k++;
                    end
                end

                if (done) begin
                    done_cnt++;
                    check("busy_at_done", 32'(busy), 32'd0);
                    check("words_at_done", 32'(pop_k), 32'(exp_count));
                end
            end
        end
    end

    task automatic start_fetch(input logic [31:0] b, input int c);
        @(posedge clock);
        #1;
        exp_base  = b;
        exp_count = c;
        acc_k     = 0;
        pop_k     = 0;
        done_cnt  = 0;
        stall_cnt = 0;
        base_addr = b;
        count     = 32'(c);
        start     = 1'b1;
        @(posedge clock);
        #1;
        start     = 1'b0;
        base_addr = $urandom;
        count     = $urandom;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            if (done_cnt > 0) break;
        end
        repeat (3) @(posedge clock);
        check("done_pulses", 32'(done_cnt), 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] b, input int c);
        start_fetch(b, c);
        @(negedge clock);
        if (c == 0) begin
            check("zero_done_next", 32'(done), 32'd1);
            check("zero_busy", 32'(busy), 32'd0);
            check("zero_no_read", 32'(vif.m_read), 32'd0);
        end else begin
            check("first_read_next", 32'(vif.m_read), 32'd1);
            check("busy_after_start", 32'(busy), 32'd1);
        end
        wait_done(3000);
    endtask

    initial begin
        vecs[0] = '{32'h0800_0000, 4,  1, 1, 0, 32'h0800_0000, 32'h0800_000C, 4};
        vecs[1] = '{32'hFFFF_FFF8, 4,  2, 1, 0, 32'hFFFF_FFF8, 32'h0000_0004, 4};
        vecs[2] = '{32'h0000_1000, 20, 3, 2, 1, 32'h0000_1000, 32'h0000_104C, 20};
        vecs[3] = '{32'hDEAD_BEE0, 1,  4, 1, 1, 32'hDEAD_BEE0, 32'hDEAD_BEE0, 1};
        vecs[4] = '{32'h7FFF_FFF0, 9,  1, 2, 0, 32'h7FFF_FFF0, 32'h8000_0010, 9};

        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_m_read", 32'(vif.m_read), 32'd0);
        check("rst_m_address", vif.m_address, 32'd0);
        check("rst_out_valid", 32'(vif.out_valid), 32'd0);
        check("rst_out_last", 32'(vif.out_last), 32'd0);
        check("rst_out_data", vif.out_data, 32'd0);
        @(posedge clock);
        #3;
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            lat        = vecs[v].lat;
            ready_mode = vecs[v].rdy;
            wait_mode  = vecs[v].wmode;
            do_fetch(vecs[v].base, vecs[v].cnt);
            check("vec_words", 32'(pop_k), 32'(vecs[v].words));
            check("vec_reads", 32'(acc_k), 32'(vecs[v].words));
            check("vec_first_addr", first_addr, vecs[v].first_a);
            check("vec_last_addr", last_addr, vecs[v].last_a);
            check("vec_idle", 32'(busy), 32'd0);
        end

        // Zero-length fetch.
        ready_mode = 1;
        wait_mode  = 0;
        lat        = 1;
        do_fetch(32'h0000_1234, 0);
        check("zero_reads", 32'(acc_k), 32'd0);

        // Backpressure: credit stops reads at FIFO depth; a start while busy is ignored.
        ready_mode = 0;
        start_fetch(32'h0000_4000, 20);
        repeat (30) @(posedge clock);
        #1;
        base_addr = 32'h0;
        count     = 32'd3;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("bp_reads", 32'(acc_k), 32'(DEPTH));
        check("bp_m_read_low", 32'(vif.m_read), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_out_valid", 32'(vif.out_valid), 32'd1);
        ready_mode = 1;
        wait_done(1000);
        check("bp_words", 32'(pop_k), 32'd20);

        // Three-cycle stall on the second read, long read latency.
        wait_mode = 2;
        lat       = 5;
        do_fetch(32'h0000_5000, 6);
        check("stall_cycles", 32'(stall_cnt), 32'd3);
        check("stall_words", 32'(pop_k), 32'd6);
        wait_mode = 0;

        // Reset mid-fetch: old words must never surface.
        lat = 2;
        start_fetch(32'h0000_2000, 10);
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            if (pop_k >= 3) break;
        end
        #2;
        reset     = 1'b1;
        exp_count = 0;
        acc_k     = 0;
        pop_k     = 0;
        done_cnt  = 0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_m_read", 32'(vif.m_read), 32'd0);
        check("abort_out_valid", 32'(vif.out_valid), 32'd0);
        check("abort_out_data", vif.out_data, 32'd0);
        @(posedge clock);
        #3;
        reset = 1'b0;
        repeat (15) @(posedge clock);
        @(negedge clock);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_fifo_empty", 32'(vif.out_valid), 32'd0);
        do_fetch(32'h0000_3000, 2);
        check("after_abort_words", 32'(pop_k), 32'd2);

        // Randomized fetches under random stalls, latency and backpressure.
        for (int t = 0; t < 12; t++) begin
            int          c;
            logic [31:0] b;
            c          = $urandom_range(0, 24);
            b          = $urandom;
            lat        = $urandom_range(1, 6);
            ready_mode = 2;
            wait_mode  = 1;
            do_fetch(b, c);
            check("rand_words", 32'(pop_k), 32'(c));
            check("rand_reads", 32'(acc_k), 32'(c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
